// File: rtl/spi_burst_arbiter_if.sv
// spi_burst_arbiter_if: bundles every requester-side and SPI-master-side signal of the arbiter.
// Latency: none (plain wires). Backpressure: none here; the arbiter's FSM paces both sides.
// Modports: master = the arbiter (drives grant/rx/m_* outputs), slave = requesters plus the SPI master.
interface spi_burst_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // requester side
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_cmd;
  logic [3*NUM_REQ-1:0] req_cnt;
  logic [2*NUM_REQ-1:0] req_mode;
  logic [8*NUM_REQ-1:0] wr_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   wr_next;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_last;
  logic [NUM_REQ-1:0]   xfer_done;
  logic                 busy;
  logic                 err;
  // SPI master side
  logic                 m_start;
  logic [7:0]           m_tx_data;
  logic                 m_cpol;
  logic                 m_cpha;
  logic [2:0]           m_read_count;
  logic [2:0]           m_write_count;
  logic                 m_ready;
  logic                 m_done;
  logic [7:0]           m_rx_data;

  modport master (
    input  req, req_cmd, req_cnt, req_mode, wr_data, m_ready, m_done, m_rx_data,
    output grant, wr_next, rx_valid, rx_data, rx_last, xfer_done, busy, err,
           m_start, m_tx_data, m_cpol, m_cpha, m_read_count, m_write_count
  );

  modport slave (
    output req, req_cmd, req_cnt, req_mode, wr_data, m_ready, m_done, m_rx_data,
    input  grant, wr_next, rx_valid, rx_data, rx_last, xfer_done, busy, err,
           m_start, m_tx_data, m_cpol, m_cpha, m_read_count, m_write_count
  );
endinterface

// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter: round-robin share of one burst-capable 8-bit SPI master among NUM_REQ requesters.
// Latency: req in IDLE -> grant next cycle (ARB) -> m_start the cycle after when m_ready=1; rx_valid/wr_next 1 cycle after m_done.
// Backpressure: launch waits for m_ready, each byte waits for m_done, release waits for m_ready.
// Ports: clk, reset (async, active-high), bus (spi_burst_arbiter_if.master: requester and SPI-master signals).
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable the XFER watchdog (TIMEOUT_CYC cycles between m_done pulses).
module spi_burst_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic               clk,
  input logic               reset,
  spi_burst_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, XFER, DRAIN} state_t;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       winner;
  logic                found;
  logic [7:0]          cmd_q;
  logic [2:0]          cnt_q;
  logic [2:0]          byte_cnt;
  logic                wr_phase;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  wr_next;
  logic [NUM_REQ-1:0]  xfer_done;
  logic                rx_valid;
  logic                rx_last;
  logic [7:0]          rx_data;
  logic                m_start;
  logic                m_cpol;
  logic                m_cpha;
  logic [2:0]          m_read_count;
  logic [2:0]          m_write_count;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0]         wdog;
  logic                err_q;
`endif

  // First requesting index at or after ptr, wrapping; ptr itself is the fallback.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[(int'(ptr) + i) % NUM_REQ]) begin
        winner = IW'((int'(ptr) + i) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      cmd_q         <= '0;
      cnt_q         <= '0;
      byte_cnt      <= '0;
      wr_phase      <= 1'b0;
      grant         <= '0;
      wr_next       <= '0;
      xfer_done     <= '0;
      rx_valid      <= 1'b0;
      rx_last       <= 1'b0;
      rx_data       <= '0;
      m_start       <= 1'b0;
      m_cpol        <= 1'b0;
      m_cpha        <= 1'b0;
      m_read_count  <= '0;
      m_write_count <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      // single-cycle pulses default low
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      wr_next   <= '0;
      xfer_done <= '0;
      m_start   <= 1'b0;

      case (state)
        IDLE: begin
          // Latching here makes grant and the new mode visible during ARB,
          // a full cycle ahead of m_start.
          if (|bus.req) begin
            owner            <= winner;
            grant            <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            cmd_q            <= bus.req_cmd[int'(winner)*8 +: 8];
            cnt_q            <= bus.req_cnt[int'(winner)*3 +: 3];
            {m_cpol, m_cpha} <= bus.req_mode[int'(winner)*2 +: 2];
            wr_phase         <= 1'b0;
            state            <= ARB;
          end
        end

        ARB: begin
          byte_cnt      <= cnt_q;
          m_read_count  <= cmd_q[7] ? 3'd0 : cnt_q;
          m_write_count <= cmd_q[7] ? cnt_q : 3'd0;
          if (bus.m_ready) begin
            m_start <= 1'b1;
          end
          state <= LAUNCH;
        end

        LAUNCH: begin
          // m_start high now means the master has taken the command byte.
          if (m_start) begin
            state <= XFER;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog  <= '0;
`endif
          end else if (bus.m_ready) begin
            m_start <= 1'b1;
          end
        end

        XFER: begin
          if (bus.m_done) begin
            rx_valid <= 1'b1;
            rx_data  <= bus.m_rx_data;
            if (byte_cnt == 3'd0) begin
              rx_last <= 1'b1;
              state   <= DRAIN;
            end else begin
              byte_cnt <= byte_cnt - 3'd1;
              if (cmd_q[7]) begin
                wr_next[owner] <= 1'b1;
                wr_phase       <= 1'b1;
              end
            end
`ifdef SPI_ARB_TIMEOUT_EN
            wdog <= '0;
          end else if (wdog == 32'(TIMEOUT_CYC - 1)) begin
            // Leaving XFER is what suppresses any late rx_valid.
            err_q <= 1'b1;
            state <= DRAIN;
          end else begin
            wdog <= wdog + 32'd1;
`endif
          end
        end

        DRAIN: begin
          if (bus.m_ready) begin
            xfer_done[owner] <= 1'b1;
            grant            <= '0;
            wr_phase         <= 1'b0;
            ptr              <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
            state            <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant         = grant;
  assign bus.wr_next       = wr_next;
  assign bus.xfer_done     = xfer_done;
  assign bus.rx_valid      = rx_valid;
  assign bus.rx_data       = rx_data;
  assign bus.rx_last       = rx_last;
  assign bus.busy          = (state != IDLE);
  assign bus.m_start       = m_start;
  assign bus.m_cpol        = m_cpol;
  assign bus.m_cpha        = m_cpha;
  assign bus.m_read_count  = m_read_count;
  assign bus.m_write_count = m_write_count;
  // Command byte first; once the first byte completes in a write burst the
  // owner's wr_data is forwarded straight through.
  assign bus.m_tx_data     = wr_phase ? bus.wr_data[int'(owner)*8 +: 8] : cmd_q;

`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err = err_q;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_burst_arbiter.sv
// tb_spi_burst_arbiter: directed bench for spi_burst_arbiter with a byte-level SPI master model.
// Latency: checks grant one cycle after req and m_start one cycle after grant.
// Backpressure: the master model holds m_ready low for the whole burst and paces m_done.
module tb_spi_burst_arbiter;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_burst_arbiter_if #(.NUM_REQ(NR)) bus ();

  spi_burst_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // master model state and stimulus tables
  logic [7:0]    miso [8];
  logic [7:0]    wbytes [NR][8];
  int            wr_ptr [NR];
  logic          stall = 1'b0;
  logic          abort_xfer = 1'b0;
  logic          mb_active;
  int            mb_total, mb_idx, mb_wait;
  int            start_rc, start_wc;

  // observation logs
  logic [7:0]    mosi_q [$];
  logic [7:0]    rx_q [$];
  logic          rxl_q [$];
  logic [NR-1:0] grant_q [$];
  logic [1:0]    mode_q [$];
  int            wrn_cnt [NR];
  int            done_cnt [NR];
  int            glitch;
  logic [1:0]    prev_mode;
  logic [NR-1:0] prev_grant;

  // byte-level SPI master: one m_done every 4 cycles, tx byte sampled mid-gap
  initial begin
    bus.m_ready = 1'b1;
    bus.m_done = 1'b0;
    bus.m_rx_data = '0;
    mb_active = 1'b0;
    mb_total = 0; mb_idx = 0; mb_wait = 0;
    forever begin
      @(negedge clk);
      bus.m_done = 1'b0;
      if (reset) begin
        mb_active = 1'b0;
        bus.m_ready = 1'b1;
      end else if (!mb_active) begin
        if (bus.m_start && bus.m_ready) begin
          mb_active = 1'b1;
          start_rc = int'(bus.m_read_count);
          start_wc = int'(bus.m_write_count);
          mb_total = 1 + start_rc + start_wc;
          mb_idx = 0;
          mb_wait = 3;
          mosi_q.push_back(bus.m_tx_data);
          bus.m_ready = 1'b0;
        end
      end else if (abort_xfer) begin
        mb_active = 1'b0;
        abort_xfer = 1'b0;
        bus.m_ready = 1'b1;
      end else if (mb_idx == mb_total) begin
        mb_active = 1'b0;
        bus.m_ready = 1'b1;
      end else if (!stall) begin
        if (mb_wait > 0) begin
          mb_wait--;
          if (mb_wait == 1 && mb_idx > 0) mosi_q.push_back(bus.m_tx_data);
        end else begin
          bus.m_rx_data = miso[mb_idx];
          bus.m_done = 1'b1;
          mb_idx++;
          mb_wait = 3;
        end
      end
    end
  end

  // requesters advance their write byte on wr_next
  initial begin
    for (int i = 0; i < NR; i++) wr_ptr[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (bus.wr_next[i] === 1'b1) begin
          wr_ptr[i]++;
          bus.wr_data[i*8 +: 8] = wbytes[i][wr_ptr[i] % 8];
        end
      end
    end
  end

  // passive monitor
  initial begin
    prev_mode = '0;
    prev_grant = '0;
    glitch = 0;
    forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) begin
        rx_q.push_back(bus.rx_data);
        rxl_q.push_back(bus.rx_last);
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.wr_next[i] === 1'b1) wrn_cnt[i]++;
        if (bus.xfer_done[i] === 1'b1) done_cnt[i]++;
      end
      if (bus.grant != '0 && prev_grant == '0) grant_q.push_back(bus.grant);
      if (bus.m_start === 1'b1) begin
        mode_q.push_back({bus.m_cpol, bus.m_cpha});
        if ({bus.m_cpol, bus.m_cpha} != prev_mode) glitch++;
      end
      prev_mode = {bus.m_cpol, bus.m_cpha};
      prev_grant = bus.grant;
    end
  end

  task automatic clear_log();
    @(posedge clk);
    mosi_q.delete(); rx_q.delete(); rxl_q.delete(); grant_q.delete(); mode_q.delete();
    for (int i = 0; i < NR; i++) begin
      wrn_cnt[i] = 0;
      done_cnt[i] = 0;
    end
    glitch = 0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int idx, input string tag);
    int n = 0;
    while (bus.xfer_done[idx] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < 400), 32'd1);
    bus.req[idx] = 1'b0;
  endtask

  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] exp_m [4] = '{2'b00, 2'b11, 2'b00, 2'b11};

  initial begin
    int n, nd;
    bus.req = '0; bus.req_cmd = '0; bus.req_cnt = '0; bus.req_mode = '0; bus.wr_data = '0;
    for (int i = 0; i < NR; i++) wrn_cnt[i] = 0;
    for (int i = 0; i < NR; i++) done_cnt[i] = 0;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_grant", bus.grant, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_m_start", bus.m_start, 0);
    check_eq("rst_mode", {bus.m_cpol, bus.m_cpha}, 0);
    check_eq("rst_m_tx_data", bus.m_tx_data, 0);
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_xfer_done", bus.xfer_done, 0);
    check_eq("rst_err", bus.err, 0);
    reset = 1'b0;
    clear_log();

    // single read: cmd 12, 2 extra bytes
    miso[0] = 8'hA5; miso[1] = 8'h3C; miso[2] = 8'h0F;
    bus.req_cmd[7:0] = 8'h12; bus.req_cnt[2:0] = 3'd2; bus.req_mode[1:0] = 2'b00;
    bus.req[0] = 1'b1;
    @(negedge clk);
    check_eq("rd_grant_lat", bus.grant, 2'b01);
    check_eq("rd_busy", bus.busy, 1);
    check_eq("rd_no_early_start", bus.m_start, 0);
    @(negedge clk);
    check_eq("rd_start_lat", bus.m_start, 1);
    check_eq("rd_cmd_byte", bus.m_tx_data, 8'h12);
    check_eq("rd_read_count", bus.m_read_count, 2);
    check_eq("rd_write_count", bus.m_write_count, 0);
    wait_done(0, "rd_done_seen");
    @(negedge clk);
    check_eq("rd_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check_eq("rd_rx0", rx_q[0], 8'hA5);
      check_eq("rd_rx1", rx_q[1], 8'h3C);
      check_eq("rd_rx2", rx_q[2], 8'h0F);
      check_eq("rd_last_flags", {rxl_q[0], rxl_q[1], rxl_q[2]}, 3'b001);
    end
    check_eq("rd_done_cnt", done_cnt[0], 1);
    check_eq("rd_no_wr_next", wrn_cnt[0], 0);
    check_eq("rd_grant_released", bus.grant, 0);
    check_eq("rd_idle", bus.busy, 0);

    // write burst: cmd 85, then 11 22 33
    clear_log();
    wr_ptr[1] = 0;
    wbytes[1][1] = 8'h11; wbytes[1][2] = 8'h22; wbytes[1][3] = 8'h33;
    for (int i = 0; i < 8; i++) miso[i] = 8'(i);
    bus.req_cmd[15:8] = 8'h85; bus.req_cnt[5:3] = 3'd3; bus.req_mode[3:2] = 2'b00;
    bus.req[1] = 1'b1;
    wait_done(1, "wr_done_seen");
    @(negedge clk);
    check_eq("wr_mosi_count", mosi_q.size(), 4);
    if (mosi_q.size() == 4) begin
      check_eq("wr_mosi0", mosi_q[0], 8'h85);
      check_eq("wr_mosi1", mosi_q[1], 8'h11);
      check_eq("wr_mosi2", mosi_q[2], 8'h22);
      check_eq("wr_mosi3", mosi_q[3], 8'h33);
    end
    check_eq("wr_next_pulses", wrn_cnt[1], 3);
    check_eq("wr_next_other", wrn_cnt[0], 0);
    check_eq("wr_write_count", start_wc, 3);
    check_eq("wr_read_count", start_rc, 0);
    check_eq("wr_done_cnt", done_cnt[1], 1);
    check_eq("wr_rx_count", rx_q.size(), 4);

    // round-robin with a mode switch between requesters
    clear_log();
    bus.req_cmd[7:0] = 8'h01; bus.req_cnt[2:0] = 3'd0; bus.req_mode[1:0] = 2'b00;
    bus.req_cmd[15:8] = 8'h02; bus.req_cnt[5:3] = 3'd0; bus.req_mode[3:2] = 2'b11;
    bus.req = 2'b11;
    nd = 0; n = 0;
    while (nd < 4 && n < 1000) begin
      @(negedge clk);
      n++;
      if (|bus.xfer_done) nd++;
    end
    bus.req = 2'b00;
    check_eq("rr_complete", nd, 4);
    @(negedge clk);
    check_eq("rr_grant_count", grant_q.size(), 4);
    check_eq("rr_mode_count", mode_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_q.size()) check_eq($sformatf("rr_grant%0d", i), grant_q[i], exp_g[i]);
      if (i < mode_q.size()) check_eq($sformatf("rr_mode%0d", i), mode_q[i], exp_m[i]);
    end
    check_eq("rr_mode_settled_before_start", glitch, 0);
    check_eq("rr_done0", done_cnt[0], 2);
    check_eq("rr_done1", done_cnt[1], 2);
    check_eq("rr_mode_held", {bus.m_cpol, bus.m_cpha}, 2'b11);

    // reset mid-transfer of a 4-byte read, then a normal transfer
    clear_log();
    miso[0] = 8'h01; miso[1] = 8'h02; miso[2] = 8'h03; miso[3] = 8'h04;
    bus.req_cmd[7:0] = 8'h30; bus.req_cnt[2:0] = 3'd3; bus.req_mode[1:0] = 2'b00;
    bus.req[0] = 1'b1;
    n = 0;
    while (rx_q.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid_first_byte", 32'(rx_q.size() >= 1), 1);
    reset = 1'b1;
    bus.req = 2'b00;
    #1;
    check_eq("rst_mid_grant", bus.grant, 0);
    check_eq("rst_mid_busy", bus.busy, 0);
    check_eq("rst_mid_rx_valid", bus.rx_valid, 0);
    check_eq("rst_mid_rx_data", bus.rx_data, 0);
    check_eq("rst_mid_start", bus.m_start, 0);
    check_eq("rst_mid_mode", {bus.m_cpol, bus.m_cpha}, 0);
    check_eq("rst_mid_read_count", bus.m_read_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_log();
    miso[0] = 8'h9A; miso[1] = 8'hBC;
    bus.req_cmd[15:8] = 8'h40; bus.req_cnt[5:3] = 3'd1; bus.req_mode[3:2] = 2'b01;
    bus.req[1] = 1'b1;
    wait_done(1, "post_rst_done_seen");
    @(negedge clk);
    check_eq("post_rst_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check_eq("post_rst_rx0", rx_q[0], 8'h9A);
      check_eq("post_rst_rx1", rx_q[1], 8'hBC);
    end
    check_eq("post_rst_done_cnt", done_cnt[1], 1);
    check_eq("post_rst_mode", mode_q.size() > 0 ? mode_q[0] : 2'bxx, 2'b01);

`ifdef SPI_ARB_TIMEOUT_EN
    // watchdog: no m_done for 16 XFER cycles
    clear_log();
    stall = 1'b1;
    bus.req_cmd[7:0] = 8'h12; bus.req_cnt[2:0] = 3'd2; bus.req_mode[1:0] = 2'b00;
    bus.req[0] = 1'b1;
    n = 0;
    while (bus.m_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_start_seen", 32'(n < 50), 1);
    repeat (16) @(negedge clk);
    check_eq("to_err_not_yet", bus.err, 0);
    @(negedge clk);
    check_eq("to_err_set", bus.err, 1);
    check_eq("to_grant_held", bus.grant, 2'b01);
    check_eq("to_busy", bus.busy, 1);
    abort_xfer = 1'b1;
    wait_done(0, "to_done_seen");
    stall = 1'b0;
    @(negedge clk);
    check_eq("to_no_rx", rx_q.size(), 0);
    check_eq("to_grant_released", bus.grant, 0);
    check_eq("to_err_sticky", bus.err, 1);
`else
    check_eq("err_tied_low", bus.err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule
